// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle of the branch predictor: IF lookup,
// EX resolution and the registered redirect back to PC-select.
interface branch_predictor_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] if_pc;
  logic                  pred_taken;
  logic [DATA_WIDTH-1:0] pred_target;
  logic                  ex_valid;
  logic [DATA_WIDTH-1:0] ex_pc;
  logic                  ex_is_bne;
  logic                  ex_eq;
  logic [DATA_WIDTH-1:0] ex_target;
  logic                  ex_pred_taken;
  logic [DATA_WIDTH-1:0] ex_pred_target;
  logic                  flush;
  logic                  mispredict;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic [DATA_WIDTH-1:0] mispredict_count;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_is_bne, ex_eq, ex_target,
           ex_pred_taken, ex_pred_target, flush,
    input  pred_taken, pred_target, mispredict, redirect_pc, mispredict_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_is_bne, ex_eq, ex_target,
           ex_pred_taken, ex_pred_target, flush,
    output pred_taken, pred_target, mispredict, redirect_pc, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit saturating BHT with a direct-mapped BTB; combinational IF lookup,
// EX training, and a one-cycle registered mispredict/redirect pulse.
module branch_predictor #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = DATA_WIDTH - INDEX_BITS - 2;

  logic [1:0]            cnt_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q [DEPTH];
  logic [DATA_WIDTH-1:0] tgt_q [DEPTH];

  logic                  mispredict_q, mispredict_d;
  logic [DATA_WIDTH-1:0] redirect_q, redirect_d;
  logic [DATA_WIDTH-1:0] count_q;

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]      if_tag, ex_tag;
  logic                  if_hit;
  logic                  upd_c;
  logic                  actual_taken;
  logic [1:0]            cnt_d;
  logic                  unused_pc_bits;

  assign if_idx = bus.if_pc[INDEX_BITS+1:2];
  assign if_tag = bus.if_pc[DATA_WIDTH-1:INDEX_BITS+2];
  assign ex_idx = bus.ex_pc[INDEX_BITS+1:2];
  assign ex_tag = bus.ex_pc[DATA_WIDTH-1:INDEX_BITS+2];
  assign unused_pc_bits = ^bus.if_pc[1:0];

  // Lookup reads only registered state, so a same-cycle update is not visible.
  assign if_hit          = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign bus.pred_taken  = if_hit && cnt_q[if_idx][1];
  assign bus.pred_target = if_hit ? tgt_q[if_idx] : '0;

  assign upd_c        = bus.ex_valid && !bus.flush;
  assign actual_taken = bus.ex_eq ^ bus.ex_is_bne;

  // Saturating counter step and mispredict/redirect decision.
  always_comb begin
    cnt_d        = cnt_q[ex_idx];
    mispredict_d = 1'b0;
    redirect_d   = '0;
    if (actual_taken) begin
      if (cnt_q[ex_idx] != 2'b11) cnt_d = cnt_q[ex_idx] + 2'd1;
    end else begin
      if (cnt_q[ex_idx] != 2'b00) cnt_d = cnt_q[ex_idx] - 2'd1;
    end
    if (upd_c) begin
      if (actual_taken && (!bus.ex_pred_taken || (bus.ex_pred_target != bus.ex_target))) begin
        mispredict_d = 1'b1;
        redirect_d   = bus.ex_target;
      end else if (!actual_taken && bus.ex_pred_taken) begin
        mispredict_d = 1'b1;
        redirect_d   = bus.ex_pc + DATA_WIDTH'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '{default: 2'b01};
      valid_q      <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      count_q      <= '0;
    end else begin
      if (upd_c) begin
        cnt_q[ex_idx] <= cnt_d;
        if (actual_taken) valid_q[ex_idx] <= 1'b1;
      end
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      if (mispredict_d) count_q <= count_q + DATA_WIDTH'(1);
    end
  end

  // Tag/target payload needs no reset; valid_q masks it.
  always_ff @(posedge clk) begin
    if (!rst && upd_c && actual_taken) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= bus.ex_target;
    end
  end

  assign bus.mispredict       = mispredict_q;
  assign bus.redirect_pc      = redirect_q;
  assign bus.mispredict_count = count_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Branch history table (BHT) with a direct-mapped branch target buffer (BTB). It sits downstream of the branch comparator in EX. It consumes the equality result for resolved BEQ/BNE branches, trains 2-bit saturating counters, and records targets. In IF it supplies a taken/not-taken prediction and a target for the fetch PC. On a wrong prediction it raises a registered redirect, one cycle after resolution, for the PC-select and flush logic.

## Interface
- DATA_WIDTH, 32, width of PCs, targets and the mispredict counter
- INDEX_BITS, 6, log2 of table depth; index = pc[INDEX_BITS+1:2]

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- if_pc  in  DATA_WIDTH  fetch PC to look up
- pred_taken  out  1  prediction for if_pc: counter[1] AND BTB hit
- pred_target  out  DATA_WIDTH  BTB target for if_pc; 0 when no hit
- ex_valid  in  1  a conditional branch is resolving in EX this cycle
- ex_pc  in  DATA_WIDTH  PC of the resolving branch
- ex_is_bne  in  1  1 = BNE, 0 = BEQ
- ex_eq  in  1  equality result from the comparator for rs1/rs2
- ex_target  in  DATA_WIDTH  computed branch target
- ex_pred_taken  in  1  prediction carried down the pipe with the branch
- ex_pred_target  in  DATA_WIDTH  predicted target carried down the pipe
- flush  in  1  EX instruction is squashed; suppresses update and mispredict
- mispredict  out  1  registered; the branch resolved last cycle was mispredicted
- redirect_pc  out  DATA_WIDTH  registered; correct next PC when mispredict=1, else 0
- mispredict_count  out  DATA_WIDTH  running mispredict total

## Operation
- Storage per entry:
  - 2-bit counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - BTB valid bit, tag pc[DATA_WIDTH-1:INDEX_BITS+2], and target.
- Lookup is combinational from registered state.
  - Hit = valid AND tag match.
  - pred_taken = hit AND counter[1].
  - pred_target = target on hit, else 0.
- Resolution: actual_taken = ex_eq XOR ex_is_bne. An update happens only when ex_valid=1 and flush=0.
- Counter update:
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
  - The counter trains regardless of BTB hit.
- BTB update when actual_taken=1: write valid=1, tag, and target=ex_target, overwriting any aliasing entry. Not-taken never writes the BTB.
- Mispredict condition, where m = direction mismatch, or (both taken and ex_pred_target != ex_target):
  - actual_taken=1, ex_pred_taken=0: m=1, redirect_pc = ex_target.
  - actual_taken=0, ex_pred_taken=1: m=1, redirect_pc = ex_pc + 4 (modulo 2^DATA_WIDTH).
  - Both taken, target mismatch: m=1, redirect_pc = ex_target.
- mispredict_count increments by 1 on each registered mispredict and wraps from all-ones to 0.
- Reset values:
  - All counters 01; all valid bits 0.
  - mispredict 0, redirect_pc 0, mispredict_count 0.
  - Tag and target contents are don't-care after reset, but pred_target must still read 0 because valid=0.

## Timing
- Lookup has zero latency: pred_* reflect if_pc in the same cycle.
- Table write lands at the clock edge ending the ex_valid cycle.
- mispredict and redirect_pc are valid for exactly one cycle, the cycle after resolution. They deassert the following cycle unless another mispredict resolves.
- Back-to-back resolutions are supported, one per cycle, each producing its own pulse.
- Same-cycle lookup and update to the same index is read-before-write: the lookup returns the old entry.
- flush=1 with ex_valid=1: no table write, no mispredict, no count change.
- rst has priority over any update in the same cycle.
  - A mispredict pending from the prior cycle is cleared if rst is asserted at the edge.
  - Tables return to reset state regardless of traffic.
- mispredict_count updates on the same edge that registers mispredict=1.

## Test plan
- **Reset defaults:** assert rst 2 cycles, release, then if_pc=0x0000_0040 -> pred_taken=0, pred_target=0, mispredict=0, mispredict_count=0.
- **Cold taken BEQ:** ex_valid=1, ex_pc=0x40, ex_is_bne=0, ex_eq=1, ex_target=0x100, ex_pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x100, count=1. Then if_pc=0x40 -> pred_taken=1 (counter 10), pred_target=0x100.
- **Saturation and NT redirect:** resolve 0x40 taken 3 more times (counter stays 11, no mispredicts with correct pred inputs). Then BEQ ex_eq=0 with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x44, counter 10, pred_taken still 1.
- **BNE polarity and target mismatch:** ex_is_bne=1, ex_eq=0, ex_pred_taken=1, ex_pred_target=0x200, ex_target=0x300 -> mispredict=1, redirect_pc=0x300, BTB target becomes 0x300.
- **Aliasing and same-cycle read:** pc 0x40 and 0x140 (INDEX_BITS=6) share an index. Update 0x140 taken while if_pc=0x140 -> same cycle pred_taken=0. Next cycle pred for 0x140 hits and 0x40 misses (pred_target=0).
- **Flush and mid-operation reset:**
  - ex_valid=1, flush=1, mispredicting inputs -> no pulse, count unchanged.
  - Mispredict resolve followed by rst at the next edge -> mispredict=0, count=0, prior entries invalid.
